sketch_counter_reader: RTL
==========================

// Module: sketch_counter_reader
// PURPOSE
// - Read-back engine for sketch counter SRAM: the reader side of the hash-and-measure counter-update path.
// - On a software command, streams a contiguous counter range (base, count) out of SRAM into a CPU-facing output FIFO.
// - Sits between the register block (command source) and the SRAM arbiter read/write ports.
// PARAMETERS
// - SRAM_ADDR_WIDTH  19  counter word address width
// - SRAM_DATA_WIDTH  36  counter word width
// - FIFO_DEPTH_BITS  3   log2 of output buffer depth (8 words)
// - RD_LATENCY       3   fixed cycles from sram_rd_ack to sram_rd_vld
// PORTS
// - clk            in   1      core clock
// - reset          in   1      synchronous, active-high
// - cmd_start      in   1      1-cycle pulse; latches cmd_base/cmd_count
// - cmd_base       in   SRAM_ADDR_WIDTH    first counter address
// - cmd_count      in   SRAM_ADDR_WIDTH+1  number of words (0 allowed)
// - cmd_abort      in   1      stop issuing; drain in-flight reads; then done
// - busy           out  1      high from accepted start until done
// - done           out  1      1-cycle pulse at end of command
// - sram_rd_req    out  1      read request, held until acked
// - sram_rd_addr   out  SRAM_ADDR_WIDTH   read address, stable while req high
// - sram_rd_ack    in   1      arbiter grant; the request is consumed this cycle
// - sram_rd_vld    in   1      read data valid (RD_LATENCY after ack)
// - sram_rd_data   in   SRAM_DATA_WIDTH  read data
// - sram_wr_req    out  1      clear write request (see CONFIGURATION)
// - sram_wr_addr   out  SRAM_ADDR_WIDTH   clear address
// - sram_wr_data   out  SRAM_DATA_WIDTH   always 0
// - sram_wr_ack    in   1      arbiter grant for the write
// - out_vld        out  1      output word available
// - out_addr       out  SRAM_ADDR_WIDTH   address of out_data
// - out_data       out  SRAM_DATA_WIDTH   counter value
// - out_rdy        in   1      consumer pops when out_vld&&out_rdy
// BEHAVIOUR
// - Reset: state=IDLE; busy, done, sram_rd_req, sram_wr_req, out_vld = 0; all addresses and counters = 0; FIFO empty.
// - FSM:
//   - IDLE -> ISSUE on cmd_start (a start while busy is ignored).
//   - ISSUE -> DRAIN when issued==count or abort.
//   - DRAIN -> DONE when in-flight==0 (and clear queue empty if enabled).
//   - DONE -> IDLE after 1 cycle, with done=1 for that cycle.
// - cmd_count==0: IDLE->ISSUE->DRAIN->DONE with no SRAM request; done is asserted 3 cycles after start.
// - Credit: assert rd_req only if in_flight + fifo_occupancy < 2**FIFO_DEPTH_BITS. The FIFO never overflows, and sram_rd_vld is always accepted.
// - rd_addr increments on each ack and wraps modulo 2**SRAM_ADDR_WIDTH. The address pipeline is RD_LATENCY deep and tags out_addr.
// - An ack and a vld in the same cycle: in_flight is unchanged. A push and a pop in the same cycle: occupancy is unchanged.
// - Output is first-word fall-through: out_vld is high whenever the FIFO is non-empty, and the words stay in address order.
// - Abort: no new req after the abort cycle. An unacked req is dropped. In-flight data is still pushed to the FIFO.
// - Reset mid-command returns to the reset state. Lost in-flight data is discarded.
// CONFIGURATION
// - Macro SKETCH_READER_CLEAR_ON_READ_EN.
//   - Defined: each returned word's address is pushed to a clear queue (same depth as the FIFO, counted in the credit). sram_wr_req writes 0 to that address until acked, which gives epoch reset of the sketch. Read has priority over write in the ISSUE state; DRAIN waits for an empty clear queue.
//   - Undefined: sram_wr_req is tied to 0, wr_addr/wr_data are tied to 0, and the queue logic is absent.
// STRUCTURE
// - Shared package opensketch_pkg holds:
//   - the FSM state encoding (IDLE, ISSUE, DRAIN, DONE);
//   - the SRAM_ADDR_WIDTH/SRAM_DATA_WIDTH constants;
//   - the RD_LATENCY default.
// - One sub-module: the output buffer is fallthrough_small_fifo (WIDTH = addr+data). The clear queue is a second instance.
// TESTING
// - base=0x10, count=4, ack every cycle, data=addr*2 -> out (0x10,0x20), (0x11,0x22), (0x12,0x24), (0x13,0x26); one done pulse; busy falls with done.
// - count=0 -> no sram_rd_req; done 3 cycles after start.
// - count=20, out_rdy=0 -> exactly 8 reads are acked, then req stays low. Release out_rdy -> all 20 words arrive in order.
// - base=0x7FFFE, count=4 -> out_addr sequence 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
// - Abort after 3 acks of count=10 -> exactly 3 words are output, then done; a start issued during busy is ignored.
// - With CLEAR_ON_READ_EN, count=2 -> two writes of 0 to base and base+1; done only after both wr_acks.

Source files
------------

// File: rtl/opensketch_pkg.sv
// Shared constants and FSM encoding for the sketch counter SRAM datapath.
package opensketch_pkg;

    localparam int SRAM_ADDR_WIDTH = 19;
    localparam int SRAM_DATA_WIDTH = 36;
    localparam int RD_LATENCY      = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } reader_state_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: rd_data shows the head whenever !empty.
module fallthrough_small_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_BITS:0]   count
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_BITS+1)'(DEPTH));
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (DEPTH_BITS+1)'(do_wr) - (DEPTH_BITS+1)'(do_rd);
        end
    end

endmodule

// File: rtl/sketch_counter_reader.sv
// Streams a contiguous sketch counter range from SRAM into a CPU-facing FIFO.
// Optional clear-on-read (epoch reset) is built with SKETCH_READER_CLEAR_ON_READ_EN.
module sketch_counter_reader #(
    parameter int SRAM_ADDR_WIDTH = opensketch_pkg::SRAM_ADDR_WIDTH,
    parameter int SRAM_DATA_WIDTH = opensketch_pkg::SRAM_DATA_WIDTH,
    parameter int FIFO_DEPTH_BITS = 3,
    parameter int RD_LATENCY      = opensketch_pkg::RD_LATENCY
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_start,
    input  logic [SRAM_ADDR_WIDTH-1:0] cmd_base,
    input  logic [SRAM_ADDR_WIDTH:0]   cmd_count,
    input  logic                       cmd_abort,
    output logic                       busy,
    output logic                       done,
    output logic                       sram_rd_req,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic                       sram_rd_ack,
    input  logic                       sram_rd_vld,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
    output logic                       sram_wr_req,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_wr_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic                       sram_wr_ack,
    output logic                       out_vld,
    output logic [SRAM_ADDR_WIDTH-1:0] out_addr,
    output logic [SRAM_DATA_WIDTH-1:0] out_data,
    input  logic                       out_rdy
);
    import opensketch_pkg::*;

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int CW    = FIFO_DEPTH_BITS + 1;

    reader_state_t              state;
    logic [SRAM_ADDR_WIDTH:0]   count;
    logic [SRAM_ADDR_WIDTH:0]   issued;
    logic [SRAM_ADDR_WIDTH:0]   issued_n;
    logic [CW-1:0]              in_flight;
    logic [CW-1:0]              in_flight_n;
    logic [CW-1:0]              fifo_cnt;
    logic [CW-1:0]              fifo_cnt_n;
    logic [CW-1:0]              clr_cnt_n;
    logic [CW+1:0]              credit_used;
    logic                       credit_ok;
    logic                       clr_idle;
    logic [RD_LATENCY:1]        vld_pipe;
    logic [SRAM_ADDR_WIDTH-1:0] addr_pipe [1:RD_LATENCY];
    logic                       fire;
    logic                       ret;
    logic                       push;
    logic                       pop;
    logic                       fifo_empty;
    logic                       fifo_full_unused;
    logic [SRAM_ADDR_WIDTH+SRAM_DATA_WIDTH-1:0] out_word;

    assign fire = sram_rd_req && sram_rd_ack;
    // Only returns tagged by our own acks are accepted; stale data after reset is dropped.
    assign ret  = vld_pipe[RD_LATENCY];
    assign push = ret && sram_rd_vld;
    assign pop  = out_vld && out_rdy;

    assign issued_n    = issued + (SRAM_ADDR_WIDTH+1)'(fire);
    assign in_flight_n = in_flight + CW'(fire) - CW'(ret);
    assign fifo_cnt_n  = fifo_cnt + CW'(push) - CW'(pop);
    // Next-cycle occupancy leaves room for the one extra ack a held request may take.
    assign credit_used = (CW+2)'(in_flight_n) + (CW+2)'(fifo_cnt_n) + (CW+2)'(clr_cnt_n);
    assign credit_ok   = credit_used < (CW+2)'(DEPTH);

    assign out_vld  = !fifo_empty;
    assign out_addr = out_word[SRAM_ADDR_WIDTH+SRAM_DATA_WIDTH-1:SRAM_DATA_WIDTH];
    assign out_data = out_word[SRAM_DATA_WIDTH-1:0];

    fallthrough_small_fifo #(
        .WIDTH      (SRAM_ADDR_WIDTH + SRAM_DATA_WIDTH),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data ({addr_pipe[RD_LATENCY], sram_rd_data}),
        .rd_en   (pop),
        .rd_data (out_word),
        .empty   (fifo_empty),
        .full    (fifo_full_unused),
        .count   (fifo_cnt)
    );

`ifdef SKETCH_READER_CLEAR_ON_READ_EN
    logic          clr_empty;
    logic          clr_pop;
    logic          clr_full_unused;
    logic [CW-1:0] clr_cnt;

    // Reads win the arbiter port; clears go out whenever no read is pending.
    assign sram_wr_req  = !clr_empty && !sram_rd_req;
    assign sram_wr_data = '0;
    assign clr_pop      = sram_wr_req && sram_wr_ack;
    assign clr_cnt_n    = clr_cnt + CW'(push) - CW'(clr_pop);
    assign clr_idle     = clr_empty;

    fallthrough_small_fifo #(
        .WIDTH      (SRAM_ADDR_WIDTH),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_clr_q (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (addr_pipe[RD_LATENCY]),
        .rd_en   (clr_pop),
        .rd_data (sram_wr_addr),
        .empty   (clr_empty),
        .full    (clr_full_unused),
        .count   (clr_cnt)
    );
`else
    logic wr_ack_unused;

    assign wr_ack_unused = sram_wr_ack;
    assign sram_wr_req   = 1'b0;
    assign sram_wr_addr  = '0;
    assign sram_wr_data  = '0;
    assign clr_cnt_n     = '0;
    assign clr_idle      = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            sram_rd_req  <= 1'b0;
            sram_rd_addr <= '0;
            count        <= '0;
            issued       <= '0;
            in_flight    <= '0;
            vld_pipe     <= '0;
            for (int i = 1; i <= RD_LATENCY; i++)
                addr_pipe[i] <= '0;
        end else begin
            done         <= 1'b0;
            in_flight    <= in_flight_n;
            vld_pipe[1]  <= fire;
            addr_pipe[1] <= sram_rd_addr;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            if (fire) begin
                sram_rd_addr <= sram_rd_addr + 1'b1;
                issued       <= issued_n;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        state        <= ST_ISSUE;
                        busy         <= 1'b1;
                        sram_rd_addr <= cmd_base;
                        count        <= cmd_count;
                        issued       <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_abort || issued_n == count) begin
                        state       <= ST_DRAIN;
                        sram_rd_req <= 1'b0;
                    end else begin
                        sram_rd_req <= credit_ok;
                    end
                end
                ST_DRAIN: begin
                    if (in_flight == '0 && clr_idle) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
